clock_mode_ctrl: RTL and testbench
==================================

# clock_mode_ctrl

Mode and time-setting controller for the digital clock's seconds/minutes/hours counter chain. Decides every cycle whether each counter steps, clears or holds. Sequences RUN → SET_HR → SET_MIN → SET_SEC from a mode button and handles increment with auto-repeat, set-mode timeout and display blink. Sits between the debounced button/tick sources and the counter chain; the counters own all arithmetic.

## Interface
- HOLD_TICKS, 8, tick_4hz pulses btn_inc must be held before auto-repeat starts (≥1)
- TIMEOUT_S, 16, tick_1hz pulses of button inactivity before a set mode returns to RUN (≥1)

- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- tick_1hz  input  1  one-cycle timebase pulse, 1 Hz
- tick_4hz  input  1  one-cycle timebase pulse, 4 Hz
- btn_mode  input  1  debounced, clk-synchronous level, 1 = pressed
- btn_inc  input  1  debounced, clk-synchronous level, 1 = pressed
- sec_at59  input  1  level, seconds counter currently holds 59
- min_at59  input  1  level, minutes counter currently holds 59
- sec_step  output  1  one-cycle pulse, seconds counter +1
- min_step  output  1  one-cycle pulse, minutes counter +1
- hr_step  output  1  one-cycle pulse, hours counter +1
- sec_clr  output  1  one-cycle pulse, seconds counter to 0
- mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN, 11 SET_SEC
- blink  output  1  display-enable for the field being set (1 = visible)

## Operation
- Edge detect: mode_rise = btn_mode & ~mode_prev; inc_rise = btn_inc & ~inc_prev. The prev registers reset to 1, so a button held through reset release is not an edge.
- FSM transitions:
  - mode_rise: RUN→SET_HR→SET_MIN→SET_SEC→RUN.
  - Timeout in any set mode: →RUN.
- RUN:
  - sec_step = tick_1hz.
  - min_step = tick_1hz & sec_at59.
  - hr_step = tick_1hz & sec_at59 & min_at59.
  - blink = 1.
  - btn_inc ignored.
- Set modes:
  - All timekeeping is frozen; no tick-driven steps.
  - SET_HR: inc_rise → hr_step.
  - SET_MIN: inc_rise → min_step.
  - SET_SEC: inc_rise → sec_clr. SET_SEC has no auto-repeat.
- Auto-repeat (SET_HR/SET_MIN only):
  - hold_cnt counts tick_4hz while btn_inc = 1 and saturates at HOLD_TICKS.
  - hold_cnt clears when btn_inc = 0 or mode changes.
  - Once hold_cnt = HOLD_TICKS, each further tick_4hz with btn_inc = 1 emits one step for the current field.
- Timeout:
  - to_cnt counts tick_1hz in set modes.
  - to_cnt clears on mode change, any mode_rise/inc_rise, or whenever btn_inc = 1.
  - When tick_1hz arrives with to_cnt = TIMEOUT_S−1, the next state is RUN.
- Blink:
  - Set to 1 on entry to any set mode.
  - Toggles on every 2nd tick_4hz, giving a 1 Hz blink at 50% duty.
  - A 1-bit divider clears on mode entry.
- Simultaneous events:
  - mode_rise and inc_rise in the same cycle: mode advances; inc ignored.
  - mode_rise and timeout in the same cycle: mode_rise wins (normal advance).
  - inc_rise and timeout in the same cycle: inc processed, timer cleared, mode kept.
  - In RUN, a mode_rise coinciding with tick_1hz still issues that tick's steps, then enters SET_HR.
  - In the cycle that leaves a set mode, the old mode's inc handling still applies. Outputs are computed from the pre-transition state.
- At most one of hr_step/min_step/sec_clr per cycle in set modes. min_step/hr_step are always gated by sec_step in RUN.

## Timing
- All outputs are registered. A trigger sampled at edge k (tick, level, or edge-detect) drives its output high for exactly the one cycle following edge k.
- mode updates at the same edge that samples mode_rise or timeout.
- Reset values:
  - mode = 00, blink = 1.
  - sec_step = min_step = hr_step = sec_clr = 0.
  - hold_cnt = to_cnt = 0, blink divider = 0.
  - mode_prev = inc_prev = 1.
- Reset asserted mid-repeat or mid-set returns to RUN immediately (asynchronously). No pulse is emitted while rst = 1.
- tick_1hz and tick_4hz may coincide; each is handled independently.

## Test plan
- Reset, then 3 tick_1hz with sec_at59 = 1, min_at59 = 1 on the 3rd → sec_step ×3; min_step and hr_step exactly once, in the same cycle as the 3rd sec_step; mode = 00.
- 4 btn_mode presses → mode 01, 10, 11, 00, each one cycle after the press edge; blink = 1 on each entry; no sec_step on tick_1hz while mode ≠ 00.
- SET_MIN, hold btn_inc across 12 tick_4hz, HOLD_TICKS = 8 → 1 min_step at the press plus 4 repeat min_step (ticks 9–12); release → no further steps.
- SET_HR, no buttons, TIMEOUT_S = 16 → mode = 00 one cycle after the 16th tick_1hz. Repeat with inc_rise on the 16th tick → hr_step and mode stays 01.
- btn_mode and btn_inc rise in the same cycle in SET_HR → mode = 10, no hr_step. In SET_SEC, inc_rise → single sec_clr.
- Hold btn_inc through rst deassertion, then enter SET_HR → no step until btn_inc is released and pressed again. Assert rst during an auto-repeat → all pulses 0, mode = 00 without a clock edge.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - mode sequencing, set-mode stepping, auto-repeat, timeout and blink for the clock counters
module clock_mode_ctrl #(
  parameter int HOLD_TICKS = 8,
  parameter int TIMEOUT_S  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_4hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sec_at59,
  input  logic       min_at59,
  output logic       sec_step,
  output logic       min_step,
  output logic       hr_step,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10,
    SET_SEC = 2'b11
  } mode_t;

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int TW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_S - 1);

  mode_t         mode_q, mode_d;
  logic          mode_prev_q, inc_prev_q;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          blink_q, blink_d;
  logic          blink_div_q, blink_div_d;
  logic          sec_step_q, sec_step_d;
  logic          min_step_q, min_step_d;
  logic          hr_step_q, hr_step_d;
  logic          sec_clr_q, sec_clr_d;

  logic mode_rise, inc_rise, inc_evt, in_set, repeat_mode, repeat_hit, timeout_hit, mode_change;

  assign mode_rise   = btn_mode & ~mode_prev_q;
  assign inc_rise    = btn_inc & ~inc_prev_q;
  assign inc_evt     = inc_rise & ~mode_rise;
  assign in_set      = (mode_q != RUN);
  assign repeat_mode = (mode_q == SET_HR) || (mode_q == SET_MIN);
  assign repeat_hit  = repeat_mode && btn_inc && tick_4hz && (hold_cnt_q == HOLD_MAX);
  // Any inc activity keeps the set mode alive, even on the expiring tick.
  assign timeout_hit = in_set && tick_1hz && !btn_inc && (to_cnt_q == TO_LAST);
  assign mode_change = (mode_d != mode_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= RUN;
      mode_prev_q <= 1'b1;
      inc_prev_q  <= 1'b1;
      hold_cnt_q  <= '0;
      to_cnt_q    <= '0;
      blink_q     <= 1'b1;
      blink_div_q <= 1'b0;
      sec_step_q  <= 1'b0;
      min_step_q  <= 1'b0;
      hr_step_q   <= 1'b0;
      sec_clr_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      mode_prev_q <= btn_mode;
      inc_prev_q  <= btn_inc;
      hold_cnt_q  <= hold_cnt_d;
      to_cnt_q    <= to_cnt_d;
      blink_q     <= blink_d;
      blink_div_q <= blink_div_d;
      sec_step_q  <= sec_step_d;
      min_step_q  <= min_step_d;
      hr_step_q   <= hr_step_d;
      sec_clr_q   <= sec_clr_d;
    end
  end

  always_comb begin
    mode_d      = mode_q;
    sec_step_d  = 1'b0;
    min_step_d  = 1'b0;
    hr_step_d   = 1'b0;
    sec_clr_d   = 1'b0;
    case (mode_q)
      RUN: begin
        sec_step_d = tick_1hz;
        min_step_d = tick_1hz & sec_at59;
        hr_step_d  = tick_1hz & sec_at59 & min_at59;
        if (mode_rise) mode_d = SET_HR;
      end
      SET_HR: begin
        hr_step_d = inc_evt | repeat_hit;
        if (mode_rise)        mode_d = SET_MIN;
        else if (timeout_hit) mode_d = RUN;
      end
      SET_MIN: begin
        min_step_d = inc_evt | repeat_hit;
        if (mode_rise)        mode_d = SET_SEC;
        else if (timeout_hit) mode_d = RUN;
      end
      default: begin
        sec_clr_d = inc_evt;
        if (mode_rise || timeout_hit) mode_d = RUN;
      end
    endcase
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (mode_change || !btn_inc || !repeat_mode) begin
      hold_cnt_d = '0;
    end else if (tick_4hz && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
    end

    to_cnt_d = to_cnt_q;
    if (mode_change || !in_set || mode_rise || inc_rise || btn_inc) begin
      to_cnt_d = '0;
    end else if (tick_1hz) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    // Divider halves tick_4hz so the field blinks at 1 Hz.
    blink_d     = blink_q;
    blink_div_d = blink_div_q;
    if (mode_change || !in_set) begin
      blink_d     = 1'b1;
      blink_div_d = 1'b0;
    end else if (tick_4hz) begin
      blink_div_d = ~blink_div_q;
      if (blink_div_q) blink_d = ~blink_q;
    end
  end

  assign sec_step = sec_step_q;
  assign min_step = min_step_q;
  assign hr_step  = hr_step_q;
  assign sec_clr  = sec_clr_q;
  assign mode     = mode_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - directed self-checking bench for clock_mode_ctrl
module tb_clock_mode_ctrl;

  logic       clk;
  logic       rst;
  logic       tick_1hz, tick_4hz, btn_mode, btn_inc, sec_at59, min_at59;
  logic       sec_step, min_step, hr_step, sec_clr, blink;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  clock_mode_ctrl #(.HOLD_TICKS(8), .TIMEOUT_S(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .tick_4hz (tick_4hz),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .sec_at59 (sec_at59),
    .min_at59 (min_at59),
    .sec_step (sec_step),
    .min_step (min_step),
    .hr_step  (hr_step),
    .sec_clr  (sec_clr),
    .mode     (mode),
    .blink    (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    cyc();
    btn_mode = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    checks++;
    if ({sec_step, min_step, hr_step, sec_clr} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses: got %b want 0000", {sec_step, min_step, hr_step, sec_clr});
    end
    checks++;
    if (mode !== 2'b00 || blink !== 1'b1) begin
      errors++; $display("FAIL reset_mode_blink: got mode %b blink %b want 00 1", mode, blink);
    end
    rst = 1'b0;
    cyc();
    checks++;
    if ({sec_step, min_step, hr_step, sec_clr} !== 4'b0000 || mode !== 2'b00) begin
      errors++; $display("FAIL reset_release: got pulses %b mode %b want 0000 00", {sec_step, min_step, hr_step, sec_clr}, mode);
    end
  endtask

  task automatic test_run();
    for (int i = 0; i < 3; i++) begin
      tick_1hz = 1'b1; sec_at59 = (i == 2); min_at59 = (i == 2);
      cyc();
      checks++;
      if (sec_step !== 1'b1 || min_step !== (i == 2) || hr_step !== (i == 2) || mode !== 2'b00) begin
        errors++; $display("FAIL run_tick[%0d]: got sec %b min %b hr %b mode %b want 1 %b %b 00", i, sec_step, min_step, hr_step, mode, (i == 2), (i == 2));
      end
      tick_1hz = 1'b0; sec_at59 = 1'b0; min_at59 = 1'b0;
      cyc();
      checks++;
      if ({sec_step, min_step, hr_step} !== 3'b000) begin
        errors++; $display("FAIL run_idle[%0d]: got %b want 000", i, {sec_step, min_step, hr_step});
      end
    end
  endtask

  task automatic test_mode_seq();
    logic [1:0] exp_mode;
    for (int i = 0; i < 4; i++) begin
      exp_mode = 2'((i + 1) % 4);
      btn_mode = 1'b1;
      cyc();
      checks++;
      if (mode !== exp_mode || blink !== 1'b1) begin
        errors++; $display("FAIL mode_seq[%0d]: got mode %b blink %b want %b 1", i, mode, blink, exp_mode);
      end
      btn_mode = 1'b0; tick_1hz = 1'b1;
      cyc();
      checks++;
      if (sec_step !== (exp_mode == 2'b00)) begin
        errors++; $display("FAIL mode_seq_tick[%0d]: got sec_step %b want %b", i, sec_step, (exp_mode == 2'b00));
      end
      tick_1hz = 1'b0;
      cyc();
    end
  endtask

  task automatic test_auto_repeat();
    press_mode();
    press_mode();
    btn_inc = 1'b1;
    cyc();
    checks++;
    if (min_step !== 1'b1 || mode !== 2'b10) begin
      errors++; $display("FAIL repeat_press: got min_step %b mode %b want 1 10", min_step, mode);
    end
    for (int t = 1; t <= 12; t++) begin
      tick_4hz = 1'b1;
      cyc();
      checks++;
      if (min_step !== (t >= 9) || hr_step !== 1'b0) begin
        errors++; $display("FAIL repeat_tick[%0d]: got min_step %b hr_step %b want %b 0", t, min_step, hr_step, (t >= 9));
      end
      tick_4hz = 1'b0;
      cyc();
      checks++;
      if (min_step !== 1'b0) begin
        errors++; $display("FAIL repeat_gap[%0d]: got min_step %b want 0", t, min_step);
      end
    end
    btn_inc = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick_4hz = 1'b1;
      cyc();
      checks++;
      if (min_step !== 1'b0) begin
        errors++; $display("FAIL repeat_release[%0d]: got min_step %b want 0", t, min_step);
      end
      tick_4hz = 1'b0;
      cyc();
    end
    press_mode();
    press_mode();
  endtask

  task automatic test_blink();
    press_mode();
    checks++;
    if (blink !== 1'b1 || mode !== 2'b01) begin
      errors++; $display("FAIL blink_entry: got blink %b mode %b want 1 01", blink, mode);
    end
    for (int k = 1; k <= 6; k++) begin
      tick_4hz = 1'b1;
      cyc();
      checks++;
      if (blink !== !(k == 2 || k == 3 || k == 6)) begin
        errors++; $display("FAIL blink_tick[%0d]: got %b want %b", k, blink, !(k == 2 || k == 3 || k == 6));
      end
      tick_4hz = 1'b0;
      cyc();
    end
    press_mode();
    checks++;
    if (blink !== 1'b1 || mode !== 2'b10) begin
      errors++; $display("FAIL blink_reentry: got blink %b mode %b want 1 10", blink, mode);
    end
    press_mode();
    press_mode();
  endtask

  task automatic test_timeout();
    press_mode();
    for (int k = 1; k <= 16; k++) begin
      tick_1hz = 1'b1;
      cyc();
      checks++;
      if (mode !== ((k == 16) ? 2'b00 : 2'b01) || sec_step !== 1'b0) begin
        errors++; $display("FAIL timeout_tick[%0d]: got mode %b sec_step %b want %b 0", k, mode, sec_step, ((k == 16) ? 2'b00 : 2'b01));
      end
      tick_1hz = 1'b0;
      cyc();
    end
    press_mode();
    for (int k = 1; k <= 15; k++) begin
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      cyc();
    end
    checks++;
    if (mode !== 2'b01) begin
      errors++; $display("FAIL timeout_pre16: got mode %b want 01", mode);
    end
    tick_1hz = 1'b1; btn_inc = 1'b1;
    cyc();
    checks++;
    if (hr_step !== 1'b1 || mode !== 2'b01) begin
      errors++; $display("FAIL timeout_inc: got hr_step %b mode %b want 1 01", hr_step, mode);
    end
    tick_1hz = 1'b0; btn_inc = 1'b0;
    cyc();
    tick_1hz = 1'b1;
    cyc();
    checks++;
    if (mode !== 2'b01 || hr_step !== 1'b0) begin
      errors++; $display("FAIL timeout_restart: got mode %b hr_step %b want 01 0", mode, hr_step);
    end
    tick_1hz = 1'b0;
    cyc();
    press_mode();
    press_mode();
    press_mode();
    checks++;
    if (mode !== 2'b00) begin
      errors++; $display("FAIL timeout_back_run: got mode %b want 00", mode);
    end
  endtask

  task automatic test_simultaneous();
    btn_mode = 1'b1; tick_1hz = 1'b1;
    cyc();
    checks++;
    if (sec_step !== 1'b1 || mode !== 2'b01) begin
      errors++; $display("FAIL sim_run_tick_mode: got sec_step %b mode %b want 1 01", sec_step, mode);
    end
    btn_mode = 1'b0; tick_1hz = 1'b0;
    cyc();
    btn_mode = 1'b1; btn_inc = 1'b1;
    cyc();
    checks++;
    if (mode !== 2'b10 || hr_step !== 1'b0 || min_step !== 1'b0) begin
      errors++; $display("FAIL sim_mode_inc: got mode %b hr %b min %b want 10 0 0", mode, hr_step, min_step);
    end
    btn_mode = 1'b0; btn_inc = 1'b0;
    cyc();
    press_mode();
    btn_inc = 1'b1;
    cyc();
    checks++;
    if (sec_clr !== 1'b1 || mode !== 2'b11 || {hr_step, min_step, sec_step} !== 3'b000) begin
      errors++; $display("FAIL sim_sec_clr: got sec_clr %b mode %b steps %b want 1 11 000", sec_clr, mode, {hr_step, min_step, sec_step});
    end
    for (int t = 1; t <= 10; t++) begin
      tick_4hz = 1'b1;
      cyc();
      checks++;
      if (sec_clr !== 1'b0) begin
        errors++; $display("FAIL sim_sec_norepeat[%0d]: got sec_clr %b want 0", t, sec_clr);
      end
      tick_4hz = 1'b0;
      cyc();
    end
    btn_inc = 1'b0;
    cyc();
    press_mode();
    checks++;
    if (mode !== 2'b00) begin
      errors++; $display("FAIL sim_back_run: got mode %b want 00", mode);
    end
  endtask

  task automatic test_reset_hold();
    rst = 1'b1; btn_inc = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    press_mode();
    for (int t = 0; t < 3; t++) begin
      cyc();
      checks++;
      if (hr_step !== 1'b0 || mode !== 2'b01) begin
        errors++; $display("FAIL hold_through_reset[%0d]: got hr_step %b mode %b want 0 01", t, hr_step, mode);
      end
    end
    btn_inc = 1'b0;
    cyc();
    btn_inc = 1'b1;
    cyc();
    checks++;
    if (hr_step !== 1'b1) begin
      errors++; $display("FAIL hold_repress: got hr_step %b want 1", hr_step);
    end
    for (int t = 1; t <= 9; t++) begin
      tick_4hz = 1'b1;
      cyc();
      checks++;
      if (hr_step !== (t == 9)) begin
        errors++; $display("FAIL hold_repeat[%0d]: got hr_step %b want %b", t, hr_step, (t == 9));
      end
      tick_4hz = 1'b0;
      cyc();
    end
    tick_4hz = 1'b1;
    cyc();
    checks++;
    if (hr_step !== 1'b1) begin
      errors++; $display("FAIL async_pre: got hr_step %b want 1", hr_step);
    end
    tick_4hz = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({sec_step, min_step, hr_step, sec_clr} !== 4'b0000 || mode !== 2'b00 || blink !== 1'b1) begin
      errors++; $display("FAIL async_reset: got pulses %b mode %b blink %b want 0000 00 1", {sec_step, min_step, hr_step, sec_clr}, mode, blink);
    end
    cyc();
    rst = 1'b0; btn_inc = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    tick_1hz = 1'b0; tick_4hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    sec_at59 = 1'b0; min_at59 = 1'b0;
    cyc();
    cyc();
    test_reset();
    test_run();
    test_mode_seq();
    test_auto_repeat();
    test_blink();
    test_timeout();
    test_simultaneous();
    test_reset_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
